mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Arbitrates the single main-memory port (4-cycle pipelined memory, 16-bit words)
//   between the I-cache fill FSM and the D-cache fill FSM, including D-cache stores.
//   Sits directly upstream of the memory model and downstream of both cache_fill_FSM
//   instances. Muxes address/data/write onto memory and routes memory_data_valid back
//   to the owning requester only. Holds one grant until its transaction completes.
// PARAMETERS
//   ADDR_W  16  address width (byte address)
//   DATA_W  16  memory word width
//   BEATS   8   words per cache block fill (block = 16 bytes)
// PORTS
//   clk            in   1       clock, all state on posedge
//   rst_n          in   1       synchronous, active-low reset
//   ic_req         in   1       I-cache fill FSM busy / wants memory
//   ic_addr        in   ADDR_W  I-cache memory_address
//   ic_gnt         out  1       I-cache owns memory port
//   ic_data_valid  out  1       memory_data_valid routed to I-cache
//   dc_req         in   1       D-cache fill or store wants memory
//   dc_wr          in   1       1 = single-word store, 0 = block fill read
//   dc_addr        in   ADDR_W  D-cache memory_address
//   dc_wdata       in   DATA_W  store data
//   dc_gnt         out  1       D-cache owns memory port
//   dc_data_valid  out  1       memory_data_valid routed to D-cache
//   mem_en         out  1       memory access strobe
//   mem_wr         out  1       memory write enable
//   mem_addr       out  ADDR_W  memory address
//   mem_wdata      out  DATA_W  memory write data
//   mem_data_valid in   1       memory returns a valid read word
// BEHAVIOUR
//   - States: IDLE, IC_OWN, DC_RD, DC_WR (registered). Reset -> IDLE, beat_cnt=0,
//     rr_last=IC (so D-cache wins first tie); ic_gnt=dc_gnt=0; mem_en=mem_wr=0;
//     mem_addr=0, mem_wdata=0, *_data_valid=0.
//   - IDLE: only ic_req -> IC_OWN; only dc_req -> DC_RD/DC_WR per dc_wr; both ->
//     port not in rr_last wins; rr_last updated on every grant. Grant visible the
//     cycle after the request is sampled (1-cycle arbitration latency).
//   - Requester holds req/addr/wr/wdata stable until gnt; arbiter does not latch them.
//   - Outputs combinational from state: gnt of owner=1; mem_en=owner_req;
//     mem_addr/mem_wr/mem_wdata = owner's signals; all mem_* zero in IDLE.
//   - IC_OWN / DC_RD: beat_cnt (3 bits, $clog2(BEATS)) increments on each
//     mem_data_valid; owner's *_data_valid = mem_data_valid, other's = 0.
//     On BEATS-th valid (beat_cnt==BEATS-1 && valid): beat_cnt->0, state->IDLE.
//     Completion independent of req dropping early.
//   - DC_WR: exactly one cycle with mem_en=mem_wr=1, then IDLE. No data_valid routed.
//   - Always >=1 IDLE cycle between grants; back-to-back requests re-arbitrate.
//   - mem_data_valid in IDLE or DC_WR: dropped, both *_data_valid=0, no counter change.
//   - Owner req deasserting before BEATS valids: grant held, counting continues.
//   - Reset mid-transaction: immediate IDLE, counter cleared; in-flight memory
//     returns after reset dropped per IDLE rule.
//   - Arbiter never modifies address; fill FSMs own address increment (+2/beat).
// STRUCTURE
//   - Shared package mem_arb_pkg: state enum {IDLE,IC_OWN,DC_RD,DC_WR}, BLOCK_BEATS=8,
//     MEM_LATENCY=4 (bench/memory use).
//   - Single module, no sub-modules; beat counter inline.
// TESTING
//   1 Reset: rst_n=0 2 cycles -> all outputs 0, state IDLE.
//   2 ic_req only, addr 16'h1230, 8 valids from cycle 4 -> ic_gnt 1 through 8th
//     valid, ic_data_valid pulses x8, dc_data_valid 0, IDLE next cycle.
//   3 ic_req & dc_req same cycle after reset -> dc_gnt first; on release ic_gnt
//     after 1 IDLE cycle; next tie goes to dc (rr alternates).
//   4 dc_req dc_wr=1 addr 16'h2230 wdata 16'hDEAD -> one cycle mem_wr=1,
//     mem_addr=2230, mem_wdata=DEAD, then IDLE.
//   5 Stray mem_data_valid in IDLE -> both *_data_valid 0, beat_cnt stays 0.
//   6 rst_n=0 after 3rd valid of dc fill -> IDLE, gnts 0; remaining valids dropped;
//     new ic_req then served with full 8-beat count.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory port arbiter.
// Holds the arbiter state encoding, the round-robin port identifier and
// block/latency constants used by the arbiter and its memory/bench neighbours.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IC_OWN = 2'd1,
    DC_RD  = 2'd2,
    DC_WR  = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_IC = 1'b0,
    PORT_DC = 1'b1
  } port_e;

  localparam int BLOCK_BEATS = 8;
  localparam int MEM_LATENCY = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Purpose: shares the single memory port between the I-cache and D-cache fill FSMs.
// Latency: grant appears one cycle after a request is sampled in IDLE; mem_* follow the owner combinationally.
// Backpressure: a grant is held until the block fill (BEATS valids) or the single store completes; losers simply keep requesting.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int BEATS  = BLOCK_BEATS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_gnt,
  output logic              ic_data_valid,
  input  logic              dc_req,
  input  logic              dc_wr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_gnt,
  output logic              dc_data_valid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_data_valid
);

  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  arb_state_e       state_q;
  logic [CNT_W-1:0] beat_cnt_q;
  port_e            rr_last_q;

  // Arbitration, ownership and beat counting; every grant returns through IDLE,
  // so back-to-back requests always re-arbitrate with the updated round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      rr_last_q  <= PORT_IC;
    end else begin
      case (state_q)
        IDLE: begin
          // Ties go to whichever port did not win last time.
          if (ic_req && (!dc_req || (rr_last_q == PORT_DC))) begin
            state_q   <= IC_OWN;
            rr_last_q <= PORT_IC;
          end else if (dc_req) begin
            state_q   <= dc_wr ? DC_WR : DC_RD;
            rr_last_q <= PORT_DC;
          end
        end
        IC_OWN, DC_RD: begin
          // Completion is driven purely by returned words, not by the requester's req.
          if (mem_data_valid) begin
            if (beat_cnt_q == LAST_BEAT) begin
              beat_cnt_q <= '0;
              state_q    <= IDLE;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        DC_WR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Port mux and valid routing decoded from the current owner; IDLE drives everything low
  // so stray memory returns are dropped there and in DC_WR.
  always_comb begin
    ic_gnt        = 1'b0;
    dc_gnt        = 1'b0;
    ic_data_valid = 1'b0;
    dc_data_valid = 1'b0;
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state_q)
      IC_OWN: begin
        ic_gnt        = 1'b1;
        ic_data_valid = mem_data_valid;
        mem_en        = ic_req;
        mem_addr      = ic_addr;
      end
      DC_RD: begin
        dc_gnt        = 1'b1;
        dc_data_valid = mem_data_valid;
        mem_en        = dc_req;
        mem_wr        = dc_wr;
        mem_addr      = dc_addr;
        mem_wdata     = dc_wdata;
      end
      DC_WR: begin
        dc_gnt    = 1'b1;
        mem_en    = dc_req;
        mem_wr    = dc_wr;
        mem_addr  = dc_addr;
        mem_wdata = dc_wdata;
      end
      default: begin
        ic_gnt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level ownership model.
// The model tracks who owns the port and how many words remain; outputs are compared every negedge.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_gnt;
  logic          ic_data_valid;
  logic          dc_req;
  logic          dc_wr;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_wdata;
  logic          dc_gnt;
  logic          dc_data_valid;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_data_valid;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(BLOCK_BEATS)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_data_valid(ic_data_valid),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_gnt(dc_gnt), .dc_data_valid(dc_data_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_valid(mem_data_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ic_pulses = 0;
  int dc_pulses = 0;
  int wr_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner 0 = nobody, 1 = I-cache, 2 = D-cache read, 3 = D-cache store.
  int m_owner   = 0;
  int m_left    = 0;
  bit m_dc_pref = 1'b1;
  bit m_dc_wins;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner   = 0;
      m_left    = 0;
      m_dc_pref = 1'b1;
    end else if (m_owner == 0) begin
      if (ic_req || dc_req) begin
        m_dc_wins = dc_req && (!ic_req || m_dc_pref);
        m_dc_pref = !m_dc_wins;
        if (m_dc_wins) begin
          m_owner = dc_wr ? 3 : 2;
          m_left  = dc_wr ? 0 : BLOCK_BEATS;
        end else begin
          m_owner = 1;
          m_left  = BLOCK_BEATS;
        end
      end
    end else if (m_owner == 3) begin
      m_owner = 0;
    end else if (mem_data_valid) begin
      m_left = m_left - 1;
      if (m_left == 0) m_owner = 0;
    end
  end

  // Per-cycle comparison against the model, plus event counters for literal checks.
  always @(negedge clk) begin
    chk("ic_gnt", 32'(ic_gnt), 32'(m_owner == 1));
    chk("dc_gnt", 32'(dc_gnt), 32'(m_owner >= 2));
    chk("ic_data_valid", 32'(ic_data_valid), 32'(m_owner == 1 && mem_data_valid));
    chk("dc_data_valid", 32'(dc_data_valid), 32'(m_owner == 2 && mem_data_valid));
    chk("mem_en", 32'(mem_en),
        32'((m_owner == 1) ? ic_req : ((m_owner >= 2) ? dc_req : 1'b0)));
    chk("mem_wr", 32'(mem_wr), 32'((m_owner >= 2) ? dc_wr : 1'b0));
    chk("mem_addr", 32'(mem_addr),
        32'((m_owner == 1) ? ic_addr : ((m_owner >= 2) ? dc_addr : 16'h0)));
    chk("mem_wdata", 32'(mem_wdata), 32'((m_owner >= 2) ? dc_wdata : 16'h0));
    if (ic_data_valid) ic_pulses++;
    if (dc_data_valid) dc_pulses++;
    if (mem_wr) wr_cycles++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Acts as the owning fill FSM plus memory: n words, each preceded by gap idle cycles.
  task automatic fill(input bit is_ic, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      tick(gap);
      mem_data_valid = 1'b1;
      tick(1);
      mem_data_valid = 1'b0;
      if (is_ic) ic_addr = ic_addr + 16'd2;
      else       dc_addr = dc_addr + 16'd2;
    end
  endtask

  initial begin
    rst_n = 1'b0; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_wr = 1'b0;
    dc_addr = '0; dc_wdata = '0; mem_data_valid = 1'b0;

    // 1: reset
    tick(2);
    @(negedge clk);
    chk("reset_outputs", {ic_gnt, dc_gnt, ic_data_valid, dc_data_valid, mem_en, mem_wr,
                          mem_addr | mem_wdata}, 32'h0);
    rst_n = 1'b1;
    tick(1);

    // 2: lone I-cache fill
    ic_req = 1'b1; ic_addr = 16'h1230;
    ic_pulses = 0; dc_pulses = 0;
    tick(1);
    @(negedge clk);
    chk("t2_gnt", 32'(ic_gnt), 32'd1);
    chk("t2_addr", 32'(mem_addr), 32'h1230);
    tick(2);
    fill(1'b1, 7, 0);
    @(negedge clk);
    chk("t2_held_after7", 32'(ic_gnt), 32'd1);
    mem_data_valid = 1'b1;
    tick(1);
    mem_data_valid = 1'b0; ic_req = 1'b0;
    @(negedge clk);
    chk("t2_released", 32'(ic_gnt), 32'd0);
    chk("t2_ic_pulses", 32'(ic_pulses), 32'd8);
    chk("t2_dc_pulses", 32'(dc_pulses), 32'd0);

    // 3: tie after reset goes to D-cache, then I-cache, then D-cache again
    tick(1);
    ic_req = 1'b1; ic_addr = 16'h1240;
    dc_req = 1'b1; dc_wr = 1'b0; dc_addr = 16'h3000;
    tick(1);
    @(negedge clk);
    chk("t3_tie1_dc", {dc_gnt, ic_gnt}, 32'b10);
    dc_req = 1'b0;
    fill(1'b0, 8, 1);
    @(negedge clk);
    chk("t3_idle_gap", {dc_gnt, ic_gnt}, 32'b00);
    tick(1);
    @(negedge clk);
    chk("t3_ic_next", 32'(ic_gnt), 32'd1);
    fill(1'b1, 8, 0);
    dc_req = 1'b1; dc_addr = 16'h3100;
    tick(1);
    @(negedge clk);
    chk("t3_tie2_dc", {dc_gnt, ic_gnt}, 32'b10);
    dc_req = 1'b0;
    fill(1'b0, 8, 0);
    tick(1);
    fill(1'b1, 8, 0);
    ic_req = 1'b0;
    tick(1);

    // 4: single store
    dc_req = 1'b1; dc_wr = 1'b1; dc_addr = 16'h2230; dc_wdata = 16'hDEAD;
    wr_cycles = 0;
    tick(1);
    @(negedge clk);
    chk("t4_wr", {mem_en, mem_wr, dc_gnt}, 32'b111);
    chk("t4_addr", 32'(mem_addr), 32'h2230);
    chk("t4_wdata", 32'(mem_wdata), 32'hDEAD);
    tick(1);
    dc_req = 1'b0; dc_wr = 1'b0;
    @(negedge clk);
    chk("t4_done", {mem_wr, dc_gnt}, 32'b00);
    tick(2);
    chk("t4_wr_cycles", 32'(wr_cycles), 32'd1);

    // 5: stray valids in IDLE, then a full fill proves the counter stayed at 0
    mem_data_valid = 1'b1;
    @(negedge clk);
    chk("t5_stray", {ic_data_valid, dc_data_valid}, 32'b00);
    tick(2);
    mem_data_valid = 1'b0;
    ic_req = 1'b1; ic_addr = 16'h6000;
    tick(1);
    fill(1'b1, 7, 0);
    @(negedge clk);
    chk("t5_held_after7", 32'(ic_gnt), 32'd1);
    mem_data_valid = 1'b1;
    tick(1);
    mem_data_valid = 1'b0; ic_req = 1'b0;
    @(negedge clk);
    chk("t5_released", 32'(ic_gnt), 32'd0);
    tick(1);

    // 6: reset in the middle of a D-cache fill
    dc_req = 1'b1; dc_wr = 1'b0; dc_addr = 16'h4000;
    tick(1);
    @(negedge clk);
    chk("t6_dc_gnt", 32'(dc_gnt), 32'd1);
    fill(1'b0, 3, 0);
    rst_n = 1'b0; dc_req = 1'b0; mem_data_valid = 1'b1;
    tick(1);
    @(negedge clk);
    chk("t6_reset_gnts", {ic_gnt, dc_gnt, dc_data_valid}, 32'b000);
    rst_n = 1'b1;
    tick(2);
    mem_data_valid = 1'b0;
    ic_req = 1'b1; ic_addr = 16'h5000;
    tick(1);
    ic_pulses = 0;
    fill(1'b1, 7, 1);
    @(negedge clk);
    chk("t6_held_after7", 32'(ic_gnt), 32'd1);
    mem_data_valid = 1'b1;
    tick(1);
    mem_data_valid = 1'b0; ic_req = 1'b0;
    @(negedge clk);
    chk("t6_released", 32'(ic_gnt), 32'd0);
    chk("t6_ic_pulses", 32'(ic_pulses), 32'd8);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
